// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: serialises one RISC-V load/store (LB/LH/LW/LBU/LHU/SB/SH/SW)
// into 1, 2 or 4 little-endian single-byte accesses to a byte-wide RAM with
// combinational read and posedge write, then issues a one-cycle response.
module lsu_byte_seq #(
   parameter int ADDR_W      = 8,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_wd,
   output logic              mem_we,
   input  logic [7:0]        mem_rd
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_reg;
   logic              we_reg;
   logic [2:0]        funct3_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [31:0]       wdata_reg;
   logic [1:0]        k_reg;
   logic [1:0]        last_k_reg;
   logic [31:0]       buf_reg;
   logic [31:0]       buf_next;
   logic [7:0]        wr_byte;
   logic              acc_bad;
   logic [1:0]        acc_last_k;

   // Request classification at acceptance: illegal size, or misaligned when checking is on.
   always_comb begin
      acc_bad = (req_funct3[1:0] == 2'b11);
      if (CHECK_ALIGN) begin
         acc_bad = acc_bad
                 | ((req_funct3[1:0] == 2'b01) & req_addr[0])
                 | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
      end
      case (req_funct3[1:0])
         2'b00:   acc_last_k = 2'd0;
         2'b01:   acc_last_k = 2'd1;
         default: acc_last_k = 2'd3;
      endcase
   end

   // Load buffer with the byte arriving this cycle merged in, so the final byte
   // can feed the registered response directly.
   for (genvar gi = 0; gi < 4; gi++) begin : g_buf
      assign buf_next[8*gi +: 8] = (state_reg == XFER && !we_reg && k_reg == 2'(gi))
                                   ? mem_rd : buf_reg[8*gi +: 8];
   end

   // Select the store byte for the current beat.
   always_comb begin
      case (k_reg)
         2'd0:    wr_byte = wdata_reg[7:0];
         2'd1:    wr_byte = wdata_reg[15:8];
         2'd2:    wr_byte = wdata_reg[23:16];
         default: wr_byte = wdata_reg[31:24];
      endcase
   end

   // RAM side: address walks base+k (wrapping) only during transfers; write data
   // mirrors read data whenever not writing so an always-enabled RAM stays intact.
   assign mem_we = (state_reg == XFER) && we_reg;
   assign mem_a  = (state_reg == XFER) ? base_reg + ADDR_W'(k_reg) : '0;
   assign mem_wd = mem_we ? wr_byte : mem_rd;

   function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] f3);
      logic [31:0] r;
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'b0, b[7:0]}  : {{24{b[7]}}, b[7:0]};
         2'b01:   r = f3[2] ? {16'b0, b[15:0]} : {{16{b[15]}}, b[15:0]};
         default: r = b;
      endcase
      return r;
   endfunction

   // Sequencer FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         we_reg     <= 1'b0;
         funct3_reg <= 3'b0;
         base_reg   <= '0;
         wdata_reg  <= 32'b0;
         k_reg      <= 2'd0;
         last_k_reg <= 2'd0;
         buf_reg    <= 32'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'b0;
         resp_err   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  we_reg     <= req_we;
                  funct3_reg <= req_funct3;
                  base_reg   <= req_addr;
                  wdata_reg  <= req_wdata;
                  k_reg      <= 2'd0;
                  last_k_reg <= acc_last_k;
                  buf_reg    <= 32'b0;
                  req_ready  <= 1'b0;
                  if (acc_bad) begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'b0;
                  end else begin
                     state_reg <= XFER;
                  end
               end
            end
            XFER: begin
               buf_reg <= buf_next;
               k_reg   <= k_reg + 2'd1;
               if (k_reg == last_k_reg) begin
                  state_reg  <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= we_reg ? 32'b0 : extend(buf_next, funct3_reg);
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'b0;
               req_ready  <= 1'b1;
               state_reg  <= IDLE;
            end
            default: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Testbench for lsu_byte_seq: two instances (alignment checking on / off) see
// identical requests, each with its own 256x8 RAM; results are compared with
// constant vectors and with a byte-array reference model.
module tb_lsu_byte_seq;

   logic        clk;
   logic        rst;
   logic        fill;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;

   logic        req_ready_s  [2];
   logic        resp_valid_s [2];
   logic        resp_err_s   [2];
   logic        mem_we_s     [2];
   logic [31:0] resp_rdata_s [2];
   logic [7:0]  mem_a_s      [2];
   logic [7:0]  mem_wd_s     [2];
   logic [7:0]  mem_rd_s     [2];

   logic [7:0]  ram [2][256];
   logic [7:0]  mdl [2][256];

   int n_cmp;
   int n_bad;

   logic [31:0] last_rd  [2];
   logic        last_err [2];

   // index 0: CHECK_ALIGN=1, index 1: CHECK_ALIGN=0
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      lsu_byte_seq #(.ADDR_W(8), .CHECK_ALIGN(gi == 0)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid),
         .req_ready  (req_ready_s[gi]),
         .req_we     (req_we),
         .req_funct3 (req_funct3),
         .req_addr   (req_addr),
         .req_wdata  (req_wdata),
         .resp_valid (resp_valid_s[gi]),
         .resp_rdata (resp_rdata_s[gi]),
         .resp_err   (resp_err_s[gi]),
         .mem_a      (mem_a_s[gi]),
         .mem_wd     (mem_wd_s[gi]),
         .mem_we     (mem_we_s[gi]),
         .mem_rd     (mem_rd_s[gi])
      );
      assign mem_rd_s[gi] = ram[gi][mem_a_s[gi]];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 73 + 29) ^ (i >> 3));
   endfunction

   // RAM models: preload while fill is high, otherwise write on posedge.
   always @(posedge clk) begin
      if (fill) begin
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) ram[d][i] <= init_byte(i);
      end else begin
         for (int d = 0; d < 2; d++)
            if (mem_we_s[d]) ram[d][mem_a_s[d]] <= mem_wd_s[d];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic ram_cmp(input string name);
      for (int d = 0; d < 2; d++) begin
         int diffs;
         diffs = 0;
         for (int i = 0; i < 256; i++)
            if (ram[d][i] !== mdl[d][i]) begin
               if (diffs == 0)
                  $display("ram dut%0d first difference at 0x%02h: ram %02h model %02h",
                           d, i, ram[d][i], mdl[d][i]);
               diffs++;
            end
         check($sformatf("%s_ram_dut%0d", name, d), diffs, 0);
      end
   endtask

   // Reference model: operation semantics from size/alignment rules on a byte array.
   function automatic void model(input int d, input bit we, input logic [2:0] f3,
                                 input logic [7:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output bit err,
                                 output int lat, output int nwr);
      int n;
      longint v;
      n   = 1 << f3[1:0];
      err = (f3[1:0] == 2'b11) || (d == 0 && (int'(addr) % n) != 0);
      rd  = 32'h0;
      nwr = 0;
      if (err) begin
         lat = 1;
         return;
      end
      lat = n + 1;
      if (we) begin
         for (int i = 0; i < n; i++) mdl[d][(int'(addr) + i) % 256] = wd[8*i +: 8];
         nwr = n;
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v = v + (longint'(mdl[d][(int'(addr) + i) % 256]) << (8 * i));
         if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
         rd = 32'(v);
      end
   endfunction

   // One operation on both instances; all outcomes checked against the model.
   task automatic run_op(input bit we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd, input bit hold);
      logic [31:0] exp_rd [2];
      bit          exp_err[2];
      int          exp_lat[2];
      int          exp_nwr[2];
      int          pulses [2];
      int          lat    [2];
      int          nwr    [2];
      logic [31:0] rd     [2];
      logic        err    [2];
      @(negedge clk);
      for (int d = 0; d < 2; d++) check($sformatf("ready_idle_dut%0d", d), req_ready_s[d], 1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      for (int d = 0; d < 2; d++) begin
         model(d, we, f3, addr, wd, exp_rd[d], exp_err[d], exp_lat[d], exp_nwr[d]);
         pulses[d] = 0; lat[d] = 0; nwr[d] = 0; rd[d] = 32'hx; err[d] = 1'bx;
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         req_valid = 1'b0;
      end else begin
         req_we     = ~we;
         req_funct3 = 3'b010;
         req_addr   = addr + 8'h40;
         req_wdata  = ~wd;
      end
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (mem_we_s[d]) nwr[d]++;
            else if (mem_wd_s[d] !== mem_rd_s[d])
               check($sformatf("wr_neutral_dut%0d", d), mem_wd_s[d], mem_rd_s[d]);
            if (resp_valid_s[d]) begin
               pulses[d]++;
               lat[d] = c;
               rd[d]  = resp_rdata_s[d];
               err[d] = resp_err_s[d];
            end
         end
         if (hold && pulses[0] > 0 && pulses[1] > 0) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("pulses_dut%0d", d), pulses[d], 1);
         check($sformatf("latency_dut%0d", d), lat[d], exp_lat[d]);
         check($sformatf("rdata_dut%0d", d), rd[d], exp_rd[d]);
         check($sformatf("err_dut%0d", d), err[d], exp_err[d]);
         check($sformatf("we_cycles_dut%0d", d), nwr[d], exp_nwr[d]);
         last_rd[d]  = rd[d];
         last_err[d] = err[d];
      end
      ram_cmp("op");
      $display("op we=%0d f3=%03b addr=%02h wd=%08h -> dut0 rd=%08h err=%0d lat=%0d | dut1 rd=%08h err=%0d lat=%0d",
               we, f3, addr, wd, rd[0], err[0], lat[0], rd[1], err[1], lat[1]);
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  f3;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [31:0] rd0;
      logic [31:0] rd1;
      bit          err0;
      bit          err1;
   } vec_t;

   vec_t tbl [17];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      tbl[0]  = '{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b0};
      tbl[1]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'b000, 8'h20, 32'h00000080, 32'h0,        32'h0,        1'b0, 1'b0};
      tbl[3]  = '{1'b0, 3'b000, 8'h20, 32'h0,        32'hFFFFFF80, 32'hFFFFFF80, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 3'b100, 8'h20, 32'h0,        32'h00000080, 32'h00000080, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 3'b001, 8'h22, 32'h00008001, 32'h0,        32'h0,        1'b0, 1'b0};
      tbl[6]  = '{1'b0, 3'b001, 8'h22, 32'h0,        32'hFFFF8001, 32'hFFFF8001, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 3'b101, 8'h22, 32'h0,        32'h00008001, 32'h00008001, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 3'b001, 8'hFF, 32'h00001234, 32'h0,        32'h0,        1'b1, 1'b0};
      tbl[9]  = '{1'b0, 3'b101, 8'hFF, 32'h0,        32'h0,        32'h00001234, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 3'b010, 8'h00, 32'hA1B2C3D4, 32'h0,        32'h0,        1'b0, 1'b0};
      tbl[11] = '{1'b1, 3'b010, 8'h04, 32'h55667788, 32'h0,        32'h0,        1'b0, 1'b0};
      tbl[12] = '{1'b0, 3'b010, 8'h02, 32'h0,        32'h0,        32'h7788A1B2, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 3'b001, 8'h03, 32'h0000CAFE, 32'h0,        32'h0,        1'b1, 1'b0};
      tbl[14] = '{1'b0, 3'b010, 8'h00, 32'h0,        32'hA1B2C3D4, 32'hFEB2C3D4, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
      tbl[16] = '{1'b1, 3'b111, 8'h30, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b1};

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) mdl[d][i] = init_byte(i);

      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 8'h0;
      req_wdata  = 32'h0;
      fill       = 1'b1;
      rst        = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ready_dut%0d", d), req_ready_s[d], 1);
         check($sformatf("rst_valid_dut%0d", d), resp_valid_s[d], 0);
         check($sformatf("rst_rdata_dut%0d", d), resp_rdata_s[d], 0);
         check($sformatf("rst_err_dut%0d", d), resp_err_s[d], 0);
         check($sformatf("rst_mem_a_dut%0d", d), mem_a_s[d], 0);
         check($sformatf("rst_mem_we_dut%0d", d), mem_we_s[d], 0);
      end
      fill = 1'b0;
      rst  = 1'b1;

      // directed vectors
      for (int v = 0; v < 17; v++) begin
         run_op(tbl[v].we, tbl[v].f3, tbl[v].addr, tbl[v].wd, 1'b0);
         check($sformatf("vec%0d_rd_dut0", v), last_rd[0], tbl[v].rd0);
         check($sformatf("vec%0d_rd_dut1", v), last_rd[1], tbl[v].rd1);
         check($sformatf("vec%0d_err_dut0", v), last_err[0], tbl[v].err0);
         check($sformatf("vec%0d_err_dut1", v), last_err[1], tbl[v].err1);
      end

      // reset in the middle of a word store: two bytes land, no response
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 8'h40;
      req_wdata  = 32'h11223344;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("abort_ready_dut%0d", d), req_ready_s[d], 1);
         check($sformatf("abort_mem_we_dut%0d", d), mem_we_s[d], 0);
         mdl[d][8'h40] = 8'h44;
         mdl[d][8'h41] = 8'h33;
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++)
            if (resp_valid_s[d] !== 1'b0 || req_ready_s[d] !== 1'b1)
               check($sformatf("abort_quiet_dut%0d", d), {resp_valid_s[d], req_ready_s[d]}, 2'b01);
      end
      for (int d = 0; d < 2; d++) check($sformatf("abort_quiet_dut%0d", d), resp_valid_s[d], 0);
      ram_cmp("abort");
      $display("abort SW 0x40 after two bytes: ram40=%02h ram41=%02h ram42=%02h ram43=%02h",
               ram[0][8'h40], ram[0][8'h41], ram[0][8'h42], ram[0][8'h43]);

      // request held through the transfer with different contents: ignored
      run_op(1'b1, 3'b010, 8'h50, 32'h0BADF00D, 1'b1);
      run_op(1'b0, 3'b010, 8'h50, 32'h0, 1'b0);
      check("hold_readback", last_rd[0], 32'h0BADF00D);

      // randomized operations against the model
      for (int t = 0; t < 160; t++) begin
         bit          we;
         logic [2:0]  f3;
         logic [7:0]  addr;
         logic [2:0]  legal [5];
         legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) f3 = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b111;
         else f3 = legal[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) addr = 8'hFC + 8'($urandom_range(0, 3));
         else addr = 8'($urandom);
         run_op(we, f3, addr, $urandom, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
